// File: rtl/lly_encode_disp_ctrl.sv
// Keypad front end: samples two active-low 8-line request groups, debounces the highest
// request, latches its channel number and scans it as two decimal digits onto one segment bus.
module lly_encode_disp_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int SCAN_DIV   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EI,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic       CLR,
  output logic [3:0] CODE,
  output logic       VALID,
  output logic       GS,
  output logic [7:0] Y,
  output logic [1:0] AN
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      cand;
  logic            s_ei;
  logic [15:0]     s_i;
  logic            raw_any;
  logic [3:0]      raw_code;
  logic            do_latch;
  logic [DW-1:0]   div;
  logic [1:0]      next_an;
  logic [3:0]      units;
  logic [7:0]      seg_next;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'h3F;
      4'd1:    glyph = 8'h06;
      4'd2:    glyph = 8'h5B;
      4'd3:    glyph = 8'h4F;
      4'd4:    glyph = 8'h66;
      4'd5:    glyph = 8'h6D;
      4'd6:    glyph = 8'h7C;
      4'd7:    glyph = 8'h07;
      4'd8:    glyph = 8'h7F;
      4'd9:    glyph = 8'h67;
      default: glyph = 8'h00;
    endcase
  endfunction

  // Ascending scan so the highest low channel wins.
  always_comb begin
    raw_code = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (!s_i[k]) raw_code = 4'(k);
    end
    raw_any  = !s_ei && (s_i != 16'hFFFF);
    do_latch = (state == DEBOUNCE) && raw_any && (raw_code == cand) && (cnt == CNT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_ei <= 1'b1;
      s_i  <= 16'hFFFF;
      GS   <= 1'b1;
    end else begin
      s_ei <= EI;
      s_i  <= {I2, I1};
      GS   <= ~raw_any;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
    end else if (s_ei) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (raw_any) begin
          state <= DEBOUNCE;
          cand  <= raw_code;
          cnt   <= '0;
        end
        DEBOUNCE: begin
          if (!raw_any || raw_code != cand) state <= IDLE;
          else if (cnt == CNT_MAX)          state <= HOLD;
          else                              cnt   <= cnt + 1'b1;
        end
        HOLD: if (!raw_any) begin
          state <= RELEASE;
          cnt   <= '0;
        end
        RELEASE: begin
          if (raw_any)             state <= HOLD;
          else if (cnt == CNT_MAX) state <= IDLE;
          else                     cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear wins over a latch on the same edge; the FSM still moves on to HOLD.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      CODE  <= 4'd0;
      VALID <= 1'b0;
    end else if (do_latch) begin
      CODE  <= cand;
      VALID <= 1'b1;
    end
  end

  always_comb begin
    next_an = (div == DIV_MAX) ? {AN[0], AN[1]} : AN;
    units   = (CODE >= 4'd10) ? CODE - 4'd10 : CODE;
    if (!VALID)                seg_next = 8'h00;
    else if (next_an == 2'b10) seg_next = (CODE >= 4'd10) ? 8'h06 : 8'h00;
    else                       seg_next = glyph(units);
  end

  // Segments are computed for the digit being selected so Y and AN move together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div <= '0;
      AN  <= 2'b01;
      Y   <= 8'h00;
    end else begin
      div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      AN  <= next_an;
      Y   <= seg_next;
    end
  end

endmodule

// File: tb/tb_lly_encode_disp_ctrl.sv
// Bench for lly_encode_disp_ctrl: directed key sequences, a streak-counting reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_lly_encode_disp_ctrl;

  localparam int DEB = 4;
  localparam int SD  = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EI  = 1'b1;
  logic       CLR = 1'b0;
  logic [7:0] I1  = 8'hFF;
  logic [7:0] I2  = 8'hFF;
  logic [3:0] CODE;
  logic       VALID;
  logic       GS;
  logic [7:0] Y;
  logic [1:0] AN;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  lly_encode_disp_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST(RST), .EI(EI), .I1(I1), .I2(I2), .CLR(CLR),
    .CODE(CODE), .VALID(VALID), .GS(GS), .Y(Y), .AN(AN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7C;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h67;  default: return 8'h00;
    endcase
  endfunction

  // Reference model: "armed" means waiting for a fresh press; streak counts agreeing
  // active samples, quiet counts inactive samples after an accepted press.
  bit         m_sei = 1'b1;
  logic [15:0] m_si = 16'hFFFF;
  bit         armed = 1'b1;
  int         streak = 0;
  int         quiet = 0;
  int         n = 0;
  int         cand = 0;
  logic [3:0] e_code = 4'd0;
  bit         e_valid = 1'b0;
  bit         e_gs = 1'b1;
  logic [7:0] e_y = 8'h00;
  logic [1:0] e_an = 2'b01;

  always @(posedge CLK) begin : model
    bit any;
    int hi;
    bit latch;
    if (RST) begin
      m_sei = 1'b1; m_si = 16'hFFFF; armed = 1'b1; streak = 0; quiet = 0; n = 0; cand = 0;
      e_code = 4'd0; e_valid = 1'b0; e_gs = 1'b1; e_y = 8'h00; e_an = 2'b01;
    end else begin
      any = !m_sei && (m_si != 16'hFFFF);
      hi = 0;
      for (int k = 0; k < 16; k++) if (!m_si[k]) hi = k;
      n++;
      e_an = (((n / SD) % 2) == 1) ? 2'b10 : 2'b01;
      if (!e_valid)            e_y = 8'h00;
      else if (e_an == 2'b10)  e_y = (e_code >= 10) ? 8'h06 : 8'h00;
      else                     e_y = glyph(int'(e_code) % 10);
      e_gs = !any;
      latch = 1'b0;
      if (m_sei) begin
        armed = 1'b1; streak = 0;
      end else if (armed) begin
        if (!any)                           streak = 0;
        else if (streak > 0 && hi != cand)  streak = 0;
        else if (streak == 0)               begin cand = hi; streak = 1; end
        else if (streak == DEB)             begin latch = 1'b1; armed = 1'b0; quiet = 0; end
        else                                streak++;
      end else begin
        if (any) quiet = 0;
        else begin
          quiet++;
          if (quiet == DEB + 1) begin armed = 1'b1; streak = 0; end
        end
      end
      if (CLR)        begin e_code = 4'd0; e_valid = 1'b0; end
      else if (latch) begin e_code = 4'(cand); e_valid = 1'b1; end
      m_sei = EI;
      m_si  = {I2, I1};
    end
  end

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("model_code",  {4'd0, CODE},  {4'd0, e_code});
      checkOutput("model_valid", {7'd0, VALID}, {7'd0, e_valid});
      checkOutput("model_gs",    {7'd0, GS},    {7'd0, e_gs});
      checkOutput("model_y",     Y,             e_y);
      checkOutput("model_an",    {6'd0, AN},    {6'd0, e_an});
    end
  end

  task automatic applyStimulus(input logic ei, input logic [7:0] i1, input logic [7:0] i2,
                               input logic clr);
    EI = ei; I1 = i1; I2 = i2; CLR = clr;
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic waitAn(input logic [1:0] t);
    int c = 0;
    while (AN !== t && c < 40) begin
      @(negedge CLK);
      c++;
    end
    checkOutput("wait_an", {6'd0, AN}, {6'd0, t});
  endtask

  initial begin
    RST = 1'b1;
    waitCycles(3);
    check_en = 1'b1;
    checkOutput("rst_code",  {4'd0, CODE}, 8'h00);
    checkOutput("rst_valid", {7'd0, VALID}, 8'h00);
    checkOutput("rst_gs",    {7'd0, GS}, 8'h01);
    checkOutput("rst_y",     Y, 8'h00);
    checkOutput("rst_an",    {6'd0, AN}, 8'h01);

    // ch3 press timeline, counted in edges after reset release
    RST = 1'b0;
    applyStimulus(1'b0, 8'hF7, 8'hFF, 1'b0);
    waitCycles(1);
    checkOutput("gs_e1", {7'd0, GS}, 8'h01);
    waitCycles(1);
    checkOutput("gs_e2", {7'd0, GS}, 8'h00);
    waitCycles(3);
    checkOutput("valid_e5", {7'd0, VALID}, 8'h00);
    waitCycles(1);
    checkOutput("valid_e6", {7'd0, VALID}, 8'h01);
    checkOutput("code_e6",  {4'd0, CODE}, 8'h03);
    waitCycles(1);
    checkOutput("an_e7",    {6'd0, AN}, 8'h01);
    checkOutput("units_y3", Y, 8'h4F);
    waitCycles(1);
    checkOutput("an_e8",    {6'd0, AN}, 8'h02);
    checkOutput("tens_blank", Y, 8'h00);
    waitCycles(2);

    // ch0 and ch10 together: ch10 wins
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);
    applyStimulus(1'b0, 8'hFE, 8'hFB, 1'b0); waitCycles(7);
    checkOutput("code_ch10", {4'd0, CODE}, 8'h0A);
    waitAn(2'b10); checkOutput("tens_y10", Y, 8'h06);
    waitAn(2'b01); checkOutput("units_y10", Y, 8'h3F);

    // clear, short glitch, then a real press of ch5
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1); waitCycles(1);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0);
    checkOutput("clr_valid", {7'd0, VALID}, 8'h00);
    checkOutput("clr_code",  {4'd0, CODE}, 8'h00);
    applyStimulus(1'b0, 8'hDF, 8'hFF, 1'b0); waitCycles(3);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(6);
    checkOutput("glitch_valid", {7'd0, VALID}, 8'h00);
    applyStimulus(1'b0, 8'hDF, 8'hFF, 1'b0); waitCycles(6);
    checkOutput("code_ch5",  {4'd0, CODE}, 8'h05);
    checkOutput("valid_ch5", {7'd0, VALID}, 8'h01);

    // ch2 held, ch15 added and ignored; minimum release, then ch15 accepted
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);
    applyStimulus(1'b0, 8'hFB, 8'hFF, 1'b0); waitCycles(7);
    checkOutput("code_ch2", {4'd0, CODE}, 8'h02);
    applyStimulus(1'b0, 8'hFB, 8'h7F, 1'b0); waitCycles(8);
    checkOutput("code_hold2", {4'd0, CODE}, 8'h02);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(5);
    applyStimulus(1'b0, 8'hFF, 8'h7F, 1'b0); waitCycles(7);
    checkOutput("code_ch15", {4'd0, CODE}, 8'h0F);
    waitAn(2'b10); checkOutput("tens_y15", Y, 8'h06);
    waitAn(2'b01); checkOutput("units_y15", Y, 8'h6D);

    // EI pulled high mid-debounce of ch9: nothing latched
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);
    applyStimulus(1'b0, 8'hFF, 8'hFD, 1'b0); waitCycles(3);
    applyStimulus(1'b1, 8'hFF, 8'hFD, 1'b0); waitCycles(3);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);
    checkOutput("ei_code",  {4'd0, CODE}, 8'h0F);
    checkOutput("ei_valid", {7'd0, VALID}, 8'h01);

    // CLR on the latch edge of ch9: cleared and not re-latched while held
    applyStimulus(1'b0, 8'hFF, 8'hFD, 1'b0); waitCycles(5);
    applyStimulus(1'b0, 8'hFF, 8'hFD, 1'b1); waitCycles(1);
    applyStimulus(1'b0, 8'hFF, 8'hFD, 1'b0);
    checkOutput("clrlatch_code",  {4'd0, CODE}, 8'h00);
    checkOutput("clrlatch_valid", {7'd0, VALID}, 8'h00);
    waitCycles(10);
    checkOutput("no_relatch", {7'd0, VALID}, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0); waitCycles(8);

    // ch7 latched, then reset together with CLR mid-operation
    applyStimulus(1'b0, 8'h7F, 8'hFF, 1'b0); waitCycles(7);
    checkOutput("code_ch7", {4'd0, CODE}, 8'h07);
    RST = 1'b1;
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1); waitCycles(1);
    checkOutput("rst2_code",  {4'd0, CODE}, 8'h00);
    checkOutput("rst2_valid", {7'd0, VALID}, 8'h00);
    checkOutput("rst2_an",    {6'd0, AN}, 8'h01);
    RST = 1'b0;
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b0);

    // idle scan: blank segments, AN 01 for 8 cycles then 10 for 8
    for (int k = 1; k <= 40; k++) begin
      waitCycles(1);
      checkOutput("idle_y", Y, 8'h00);
      checkOutput("idle_an", {6'd0, AN}, (((k / 8) % 2) == 1) ? 8'h02 : 8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
